// File: rtl/logic_gates_checker.sv
// Self-test sequencer for a 2-input gate bank: sweeps {a,b}, samples the seven gate outputs, reports pass/fail.
// Optional ERR_CNT_EN macro builds the saturating mismatch counter on err_cnt.
module logic_gates_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       nand_in,
  input  logic       nor_in,
  input  logic       not_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [1:0] fail_vec,
  output logic [7:0] err_cnt
);

  localparam int unsigned CNT_W = 8;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end
  if (NUM_PASSES < 1 || NUM_PASSES > 255) begin : g_bad_passes
    $error("NUM_PASSES must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       vector;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] pass_cnt;
  logic [6:0]       exp_c;
  logic [6:0]       obs_c;
  logic [6:0]       mism_c;

  // Golden response for the currently driven vector, bit order {xnor,xor,not,nor,nand,or,and}
  always_comb begin
    exp_c  = {~(a ^ b), a ^ b, ~a, ~(a | b), ~(a & b), a | b, a & b};
    obs_c  = {xnor_in, xor_in, not_in, nor_in, nand_in, or_in, and_in};
    mism_c = exp_c ^ obs_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vector     <= 2'd0;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= 7'd0;
      fail_vec   <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 7'd0;
            fail_vec  <= 2'd0;
            vector    <= 2'd0;
            pass_cnt  <= '0;
          end
        end
        DRIVE: begin
          a          <= vector[1];
          b          <= vector[0];
          settle_cnt <= CNT_W'(SETTLE_CYCLES);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == CNT_W'(1)) state <= CHECK;
          else settle_cnt <= settle_cnt - CNT_W'(1);
        end
        CHECK: begin
          fail_mask <= fail_mask | mism_c;
          // An empty mask means no earlier mismatch in this run
          if ((mism_c != 7'd0) && (fail_mask == 7'd0)) fail_vec <= {a, b};
          vector <= vector + 2'd1;
          if (vector == 2'd3) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
            if ((pass_cnt + CNT_W'(1)) < CNT_W'(NUM_PASSES)) begin
              state <= DRIVE;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= ((fail_mask | mism_c) == 7'd0);
            end
          end else begin
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ERR_CNT_EN
  logic accept_c;
  assign accept_c = start && ((state == IDLE) || (state == DONE));

  // Counts CHECK cycles with any mismatch, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (accept_c) begin
      err_cnt <= 8'd0;
    end else if ((state == CHECK) && (mism_c != 7'd0) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_logic_gates_checker.sv
// Directed bench for logic_gates_checker: behavioural gate bank with selectable faults, immediate-assertion checks.
module tb_logic_gates_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2;
  int         mode;
  int         n_assert = 0;
  int         n_fail = 0;

  logic       a1, b1, busy1, done1, pass1;
  logic [6:0] mask1, bank1;
  logic [1:0] vec1;
  logic [7:0] err1;

  logic       a2, b2, busy2, done2, pass2;
  logic [6:0] mask2, bank2;
  logic [1:0] vec2;
  logic [7:0] err2;

  always #5 clk = ~clk;

  // Gate bank model {xnor,xor,not,nor,nand,or,and}; mode 1: xor stuck 0, mode 2: not driven by ~b
  function automatic logic [6:0] bank(input logic x, input logic y, input int m);
    logic xo, nt;
    xo = (m == 1) ? 1'b0 : (x ^ y);
    nt = (m == 2) ? ~y : ~x;
    return {~(x ^ y), xo, nt, ~(x | y), ~(x & y), x | y, x & y};
  endfunction

  assign bank1 = bank(a1, b1, mode);
  assign bank2 = bank(a2, b2, mode);

  logic_gates_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .and_in(bank1[0]), .or_in(bank1[1]), .nand_in(bank1[2]), .nor_in(bank1[3]),
    .not_in(bank1[4]), .xor_in(bank1[5]), .xnor_in(bank1[6]),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(mask1), .fail_vec(vec1), .err_cnt(err1)
  );

  logic_gates_checker #(.SETTLE_CYCLES(5), .NUM_PASSES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .and_in(bank2[0]), .or_in(bank2[1]), .nand_in(bank2[2]), .nor_in(bank2[3]),
    .not_in(bank2[4]), .xor_in(bank2[5]), .xnor_in(bank2[6]),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(mask2), .fail_vec(vec2), .err_cnt(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run on u_dut; start re-pulsed before edge 'poke' (0 = never); edge 1 is the accepting edge
  task automatic run1(input int poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 8'(busy1), 8'd1);
    chk("done_cleared", 8'(done1), 8'd0);
    for (int e = 2; e <= 16; e++) begin
      if (e == poke) start = 1'b1;
      tick();
      start = 1'b0;
      if (e == 3 || e == 7 || e == 11 || e == 15)
        chk("ab_seq", 8'({a1, b1}), 8'((e - 3) / 4));
    end
    chk("done_not_early", 8'(done1), 8'd0);
    chk("busy_before_done", 8'(busy1), 8'd1);
    tick();
    chk("done_at_17", 8'(done1), 8'd1);
    chk("busy_off_at_done", 8'(busy1), 8'd0);
  endtask

  logic [7:0] exp_err2, exp_err4;

  initial begin
`ifdef ERR_CNT_EN
    exp_err2 = 8'd2;
    exp_err4 = 8'd4;
`else
    exp_err2 = 8'd0;
    exp_err4 = 8'd0;
`endif
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0;
    repeat (2) tick();
    chk("rst_ab", 8'({a1, b1}), 8'd0);
    chk("rst_busy", 8'(busy1), 8'd0);
    chk("rst_done", 8'(done1), 8'd0);
    chk("rst_pass", 8'(pass1), 8'd0);
    chk("rst_mask", 8'(mask1), 8'd0);
    chk("rst_vec", 8'(vec1), 8'd0);
    chk("rst_err", err1, 8'd0);
    rst_n = 1'b1;
    tick();

    // Correct bank
    run1(0);
    chk("clean_pass", 8'(pass1), 8'd1);
    chk("clean_mask", 8'(mask1), 8'd0);
    chk("clean_vec", 8'(vec1), 8'd0);
    chk("clean_err", err1, 8'd0);
    chk("hold_last_ab", 8'({a1, b1}), 8'd3);

    // xor stuck at 0: misses on 01 and 10
    mode = 1;
    run1(0);
    chk("xor_pass", 8'(pass1), 8'd0);
    chk("xor_mask", 8'(mask1), 8'b0100000);
    chk("xor_vec", 8'(vec1), 8'd1);
    chk("xor_err", err1, exp_err2);

    // not driven by ~b, with a start re-pulse mid-run that must be ignored
    mode = 2;
    run1(5);
    chk("not_pass", 8'(pass1), 8'd0);
    chk("not_mask", 8'(mask1), 8'b0010000);
    chk("not_vec", 8'(vec1), 8'd1);
    chk("not_err", err1, exp_err2);

    // Restart from DONE with a good bank clears prior results
    mode = 0;
    run1(0);
    chk("rerun_pass", 8'(pass1), 8'd1);
    chk("rerun_mask", 8'(mask1), 8'd0);
    chk("rerun_err", err1, 8'd0);

    // Reset mid-run at edge 8
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_rst_busy", 8'(busy1), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ab", 8'({a1, b1}), 8'd0);
    chk("midrst_busy", 8'(busy1), 8'd0);
    chk("midrst_mask", 8'(mask1), 8'd0);
    chk("midrst_vec", 8'(vec1), 8'd0);
    chk("midrst_err", err1, 8'd0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("abandoned_done", 8'(done1), 8'd0);
    chk("abandoned_busy", 8'(busy1), 8'd0);
    mode = 0;
    run1(0);
    chk("post_rst_pass", 8'(pass1), 8'd1);
    chk("post_rst_mask", 8'(mask1), 8'd0);

    // SETTLE_CYCLES=5, NUM_PASSES=2: done 57 edges after start, edge 1 included
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("p2_busy", 8'(busy2), 8'd1);
    repeat (55) tick();
    chk("p2_done_not_early", 8'(done2), 8'd0);
    tick();
    chk("p2_done_at_57", 8'(done2), 8'd1);
    chk("p2_pass", 8'(pass2), 8'd1);
    chk("p2_mask", 8'(mask2), 8'd0);

    // Two passes with xor stuck: four mismatching samples
    mode = 1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (55) tick();
    chk("p2x_done_not_early", 8'(done2), 8'd0);
    tick();
    chk("p2x_done", 8'(done2), 8'd1);
    chk("p2x_pass", 8'(pass2), 8'd0);
    chk("p2x_mask", 8'(mask2), 8'b0100000);
    chk("p2x_vec", 8'(vec2), 8'd1);
    chk("p2x_err", err2, exp_err4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
